tx_symbol_scheduler: RTL

Transmit-side symbol scheduler for the PCIe/USB PHY. It feeds the 8b/10b encoder one 8-bit symbol plus K flag per clock. After enable it sequences link training ordered sets, then arbitrates between the upstream data byte stream, logical idle and periodic SKP ordered-set insertion. It sits between the link-layer byte source and `enconder`; its `out_8b`/`out_K` connect directly to the encoder's `in_8b`/`K`.

---
 rtl/tx_symbol_scheduler_pkg.sv | 29 ++
 rtl/tx_symbol_scheduler_if.sv | 23 ++
 rtl/tx_symbol_scheduler_skp_timer.sv | 27 ++
 rtl/tx_symbol_scheduler.sv | 127 ++++++++++++
 4 files changed

// File: rtl/tx_symbol_scheduler_pkg.sv
// Shared symbol constants, FSM state encoding and output bundle for the
// transmit symbol scheduler; the decoder side and checkers reuse these.
package tx_symbol_scheduler_pkg;

    // 8b/10b code-group payloads (K flag carried separately)
    localparam logic [7:0] SYM_COM    = 8'hBC;  // K28.5
    localparam logic [7:0] SYM_SKP    = 8'h1C;  // K28.0
    localparam logic [7:0] SYM_IDL    = 8'h00;  // D0.0
    localparam logic [7:0] SYM_TS1_ID = 8'h4A;  // D10.2

    // TS1 ordered set: COM followed by seven TS1 identifiers
    localparam int TS1_LEN = 8;

    typedef enum logic [1:0] {
        ST_DISABLED = 2'd0,
        ST_TRAIN    = 2'd1,
        ST_ACTIVE   = 2'd2,
        ST_SKP_OS   = 2'd3
    } sched_state_t;

    // Registered symbol presented to the encoder
    typedef struct packed {
        logic [7:0] data;
        logic       k;
        logic       valid;
        logic       link_up;
    } sym_out_t;

endpackage

// File: rtl/tx_symbol_scheduler_if.sv
// Byte-source / encoder-side signal bundle of the transmit symbol scheduler.
interface tx_symbol_scheduler_if;
    logic       enable;
    logic [7:0] data_in;
    logic       data_valid;
    logic       data_ready;
    logic [7:0] out_8b;
    logic       out_K;
    logic       out_valid;
    logic       link_up;

    // Driver side: management enable plus upstream byte source
    modport master (
        output enable, data_in, data_valid,
        input  data_ready, out_8b, out_K, out_valid, link_up
    );

    // Scheduler side
    modport slave (
        input  enable, data_in, data_valid,
        output data_ready, out_8b, out_K, out_valid, link_up
    );
endinterface

// File: rtl/tx_symbol_scheduler_skp_timer.sv
// Counts ACTIVE-phase symbols and flags when a SKP ordered set is owed.
module skp_timer #(
    parameter int SKP_INTERVAL = 64
) (
    input  logic clk,
    input  logic rst,
    input  logic count_en,
    input  logic clear,
    output logic skp_due
);
    localparam int CW = $clog2(SKP_INTERVAL + 1);

    logic [CW-1:0] count_reg;

    // Clear has priority; the FSM never counts once due, so no wrap occurs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_reg <= '0;
        end else if (clear) begin
            count_reg <= '0;
        end else if (count_en) begin
            count_reg <= count_reg + 1'b1;
        end
    end

    assign skp_due = (count_reg == CW'(SKP_INTERVAL));
endmodule

// File: rtl/tx_symbol_scheduler.sv
// Transmit symbol scheduler: link training, then data/idle with periodic SKP
// ordered-set insertion. One symbol per clock toward the 8b/10b encoder.
module tx_symbol_scheduler
    import tx_symbol_scheduler_pkg::*;
#(
    parameter int TS_COUNT     = 16,
    parameter int SKP_INTERVAL = 64,
    parameter int SKP_LEN      = 3
) (
    input  logic                  clk,
    input  logic                  reset,
    tx_symbol_scheduler_if.slave  bus
);
    localparam int TSW = $clog2(TS_COUNT + 1);

    sched_state_t state_reg, state_next;
    logic [2:0]   idx_reg, idx_next;
    logic [TSW-1:0] ts_cnt_reg, ts_cnt_next, ts_cnt_inc;
    sym_out_t     out_reg, out_next;
    logic         timer_count_en;
    logic         timer_clear;
    logic         skp_due;
    logic         data_ready_comb;

    skp_timer #(.SKP_INTERVAL(SKP_INTERVAL)) u_skp_timer (
        .clk      (clk),
        .rst      (reset),
        .count_en (timer_count_en),
        .clear    (timer_clear),
        .skp_due  (skp_due)
    );

    assign ts_cnt_inc = ts_cnt_reg + 1'b1;

    // Next state and next symbol: outputs describe what leaves on the next edge
    always_comb begin
        state_next      = state_reg;
        idx_next        = idx_reg;
        ts_cnt_next     = ts_cnt_reg;
        out_next        = '{data: SYM_IDL, k: 1'b0, valid: 1'b0, link_up: 1'b0};
        timer_count_en  = 1'b0;
        timer_clear     = 1'b0;
        data_ready_comb = 1'b0;

        case (state_reg)
            ST_DISABLED: begin
                timer_clear = 1'b1;
                if (bus.enable) begin
                    // First COM of training goes out on the edge that sees enable
                    out_next    = '{data: SYM_COM, k: 1'b1, valid: 1'b1, link_up: 1'b0};
                    state_next  = ST_TRAIN;
                    idx_next    = 3'd1;
                    ts_cnt_next = '0;
                end
            end

            ST_TRAIN: begin
                timer_clear   = 1'b1;
                out_next.data = (idx_reg == 3'd0) ? SYM_COM : SYM_TS1_ID;
                out_next.k    = (idx_reg == 3'd0);
                out_next.valid = 1'b1;
                if (idx_reg == 3'(TS1_LEN - 1)) begin
                    // Enable is only honoured at ordered-set boundaries
                    idx_next    = 3'd0;
                    ts_cnt_next = ts_cnt_inc;
                    if (!bus.enable) begin
                        state_next = ST_DISABLED;
                    end else if (ts_cnt_inc == TSW'(TS_COUNT)) begin
                        state_next = ST_ACTIVE;
                    end
                end else begin
                    idx_next = idx_reg + 3'd1;
                end
            end

            ST_ACTIVE: begin
                if (!bus.enable) begin
                    state_next  = ST_DISABLED;
                    timer_clear = 1'b1;
                end else if (skp_due) begin
                    out_next    = '{data: SYM_COM, k: 1'b1, valid: 1'b1, link_up: 1'b1};
                    state_next  = ST_SKP_OS;
                    idx_next    = 3'd1;
                    timer_clear = 1'b1;
                end else begin
                    data_ready_comb = 1'b1;
                    timer_count_en  = 1'b1;
                    out_next.data    = bus.data_valid ? bus.data_in : SYM_IDL;
                    out_next.valid   = 1'b1;
                    out_next.link_up = 1'b1;
                end
            end

            ST_SKP_OS: begin
                out_next = '{data: SYM_SKP, k: 1'b1, valid: 1'b1, link_up: 1'b1};
                if (idx_reg == 3'(SKP_LEN)) begin
                    state_next = bus.enable ? ST_ACTIVE : ST_DISABLED;
                end else begin
                    idx_next = idx_reg + 3'd1;
                end
            end

            default: state_next = ST_DISABLED;
        endcase
    end

    // State, counters and registered symbol outputs
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg  <= ST_DISABLED;
            idx_reg    <= 3'd0;
            ts_cnt_reg <= '0;
            out_reg    <= '0;
        end else begin
            state_reg  <= state_next;
            idx_reg    <= idx_next;
            ts_cnt_reg <= ts_cnt_next;
            out_reg    <= out_next;
        end
    end

    assign bus.data_ready = data_ready_comb;
    assign bus.out_8b     = out_reg.data;
    assign bus.out_K      = out_reg.k;
    assign bus.out_valid  = out_reg.valid;
    assign bus.link_up    = out_reg.link_up;
endmodule
